riscv_decode_issue: RTL and testbench
=====================================

# riscv_decode_issue

Decode-and-issue stage for the RISC-V core, sitting directly upstream of `riscv_regfile`. It accepts fetched instructions over a valid/ready handshake and extracts the register addresses and the immediate. A 32-entry scoreboard tracks destination registers with in-flight writes, and the stage stalls on any read-after-write hazard. When no hazard exists, it issues to execute and drives the register file read addresses and write enable.

## Interface
- `SCNT_W`, default 16: width of the saturating stall counter.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous and active-high.
- `instr_valid_i`  in  1  fetch presents an instruction.
- `instr_i`  in  32  instruction word.
- `pc_i`  in  32  PC of `instr_i`.
- `instr_ready_o`  out  1  stage can accept an instruction.
- `flush_i`  in  1  synchronous; drops the held instruction.
- `wb_valid_i`  in  1  a writeback commits this cycle.
- `wb_rd_i`  in  5  destination of that writeback.
- `AddrA_o`  out  5  rs1 to the regfile; 0 if rs1 is unused.
- `AddrB_o`  out  5  rs2 to the regfile; 0 if rs2 is unused.
- `AddrD_o`  out  5  rd; 0 if the instruction does not write.
- `RegWEn_o`  out  1  issued instruction writes rd≠0.
- `issue_valid_o`  out  1  decoded instruction is available to execute.
- `issue_ready_i`  in  1  execute accepts it.
- `opcode_o`  out  7  opcode field.
- `funct3_o`  out  3  funct3 field.
- `funct7_o`  out  7  funct7 field.
- `imm_o`  out  32  sign-extended immediate.
- `pc_o`  out  32  PC of the issued instruction.
- `illegal_o`  out  1  opcode not in the supported set.
- `stall_cnt_o`  out  SCNT_W  number of hazard-stall cycles, saturating.

## Operation
- FSM states: IDLE, CHECK, ISSUE.
- IDLE:
  - `instr_ready_o`=1.
  - On `instr_valid_i`, capture `instr_i`/`pc_i` and go to CHECK.
- CHECK:
  - Decode the held word.
  - Hazard = (rs1 used and pending[rs1]) or (rs2 used and pending[rs2]).
  - On hazard: stay in CHECK and increment `stall_cnt_o`; it saturates at all-ones.
  - Otherwise: register the decode outputs and go to ISSUE.
- ISSUE:
  - `issue_valid_o`=1; all outputs stay stable until the handshake completes.
  - On `issue_ready_i`: if `RegWEn_o`, set pending[rd].
  - `instr_ready_o`=`issue_ready_i` (combinational). A simultaneous `instr_valid_i` is captured and the FSM goes to CHECK; otherwise it goes to IDLE.
- Opcode classes and decode:
  - R (0110011): uses rs1 and rs2; writes rd.
  - I-ALU (0010011), LOAD (0000011), JALR (1100111): use rs1; write rd; I-immediate.
  - S (0100011): uses rs1 and rs2; no write; S-immediate.
  - B (1100011): uses rs1 and rs2; no write; B-immediate (bit 0 = 0).
  - LUI (0110111), AUIPC (0010111): no source registers; write rd; U-immediate (low 12 bits = 0).
  - JAL (1101111): no source registers; writes rd; J-immediate (bit 0 = 0).
  - Any other opcode: `illegal_o`=1, no source registers, no write, `imm_o`=0. The instruction is still issued.
- Scoreboard:
  - 32-bit pending vector. Bit 0 is never set.
  - `wb_valid_i` clears pending[`wb_rd_i`].
  - If a set and a clear target the same register in the same cycle, set wins.
  - A clear is visible to CHECK from the next cycle; there is no same-cycle bypass.
- `flush_i`:
  - From any state, go to IDLE and deassert `issue_valid_o`.
  - The scoreboard is untouched, because already-issued instructions still write back.
  - `flush_i` has priority over any handshake in the same cycle.
- Reset values: state IDLE, pending all 0, `stall_cnt_o`=0, every data output 0, `issue_valid_o`=0, `instr_ready_o`=1.
- Reset asserted mid-operation discards the held instruction and the scoreboard immediately.

## Timing
- Minimum latency from accept to issue:
  - Accept in cycle N, CHECK in N+1, `issue_valid_o` in N+2.
- Throughput:
  - One instruction per 2 cycles when there are no hazards and no backpressure.
- `AddrA_o`/`AddrB_o` are valid from the first CHECK cycle through the issue handshake.
  - This lets the regfile's registered read complete in that window.
- `RegWEn_o`/`AddrD_o` are qualified by `issue_valid_o`.
- Each stall extends CHECK by one cycle.
  - The earliest issue is 2 cycles after the cycle in which the blocking writeback is presented.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) at pc 0x100:
  - `issue_valid_o` in the 2nd cycle after accept.
  - `AddrD_o`=1, `imm_o`=5, `RegWEn_o`=1, `AddrA_o`=0, `pc_o`=0x100.
- RAW hazard: issue `addi x1,...`, then `add x2,x1,x1` (0x00108133):
  - The second instruction holds in CHECK and `stall_cnt_o` counts.
  - `wb_valid_i`=1 with `wb_rd_i`=1 releases it; issue follows 2 cycles later.
- Immediate decode checks:
  - `beq x0,x0,-4` (0xFE000EE3) gives `imm_o`=0xFFFFFFFC and `RegWEn_o`=0.
  - `lui x5,0x12345` (0x123452B7) gives `imm_o`=0x12345000.
- Backpressure: hold `issue_ready_i`=0 for 5 cycles.
  - Outputs stay stable and `instr_ready_o`=0.
  - On release, a waiting instruction is accepted in that same cycle.
- Same-cycle set and clear of x3: pending[3] remains 1.
  - A writer to x0 never sets the scoreboard.
- Flush and reset:
  - `flush_i` during ISSUE returns the FSM to IDLE with `issue_valid_o`=0 next cycle and the scoreboard unchanged.
  - Async `rst_i` mid-stall clears all outputs before the next clock edge.
- Unknown opcode 0x0000007F: `illegal_o`=1, the instruction is issued, and the scoreboard is unchanged.

Source files
------------

// File: rtl/riscv_decode_issue.sv
// Decode-and-issue stage: holds one fetched instruction, waits out RAW hazards against a
// 32-entry pending-write scoreboard, then presents the decoded fields to execute.
module riscv_decode_issue #(
  parameter int SCNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_valid_i,
  input  logic [31:0]       instr_i,
  input  logic [31:0]       pc_i,
  output logic              instr_ready_o,
  input  logic              flush_i,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_rd_i,
  output logic [4:0]        AddrA_o,
  output logic [4:0]        AddrB_o,
  output logic [4:0]        AddrD_o,
  output logic              RegWEn_o,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output logic [6:0]        opcode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [31:0]       imm_o,
  output logic [31:0]       pc_o,
  output logic              illegal_o,
  output logic [SCNT_W-1:0] stall_cnt_o,
  output logic [1:0]        dbg_state_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_instr;
  logic [31:0]       r_pc;
  logic [31:0]       r_pending;
  logic [31:0]       w_pending_nxt;
  logic [SCNT_W-1:0] r_stall_cnt;

  logic [6:0]        r_opcode;
  logic [2:0]        r_funct3;
  logic [6:0]        r_funct7;
  logic [31:0]       r_imm;
  logic [31:0]       r_pc_out;
  logic              r_illegal;
  logic [4:0]        r_addr_d;
  logic              r_regwen;

  logic [6:0]        w_opcode;
  logic [4:0]        w_rd;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [31:0]       w_imm_i;
  logic [31:0]       w_imm_s;
  logic [31:0]       w_imm_b;
  logic [31:0]       w_imm_u;
  logic [31:0]       w_imm_j;
  logic [31:0]       w_imm;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic              w_writes;
  logic              w_illegal;
  logic              w_hazard;
  logic              w_instr_ready;
  logic              w_accept;
  logic              w_issue_fire;
  logic              w_decode_done;
  logic              w_stall;

  // Field extraction from the held word.
  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_funct3 = r_instr[14:12];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_funct7 = r_instr[31:25];

  assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_s = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                    r_instr[11:8], 1'b0};
  assign w_imm_u = {r_instr[31:12], 12'h000};
  assign w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                    r_instr[30:21], 1'b0};

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_writes  = 1'b0;
    w_illegal = 1'b0;
    w_imm     = 32'h0;
    case (w_opcode)
      OP_R: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_writes  = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        w_use_rs1 = 1'b1;
        w_writes  = 1'b1;
        w_imm     = w_imm_i;
      end
      OP_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm     = w_imm_s;
      end
      OP_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm     = w_imm_b;
      end
      OP_LUI, OP_AUIPC: begin
        w_writes = 1'b1;
        w_imm    = w_imm_u;
      end
      OP_JAL: begin
        w_writes = 1'b1;
        w_imm    = w_imm_j;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Pending is read as registered state, so a writeback clear is only seen a cycle later.
  assign w_hazard = (w_use_rs1 && r_pending[w_rs1]) || (w_use_rs2 && r_pending[w_rs2]);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high at the
  // rising edge and flush_i is low; flush_i cancels any transfer in its cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_instr_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_instr_ready = 1'b1;
        if (instr_valid_i) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (!w_hazard) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_instr_ready = issue_ready_i;
        if (issue_ready_i) w_state_nxt = instr_valid_i ? ST_CHECK : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush_i) w_state_nxt = ST_IDLE;
  end

  assign w_accept      = instr_valid_i && w_instr_ready && !flush_i;
  assign w_issue_fire  = (r_state == ST_ISSUE) && issue_ready_i && !flush_i;
  assign w_decode_done = (r_state == ST_CHECK) && !w_hazard && !flush_i;
  assign w_stall       = (r_state == ST_CHECK) && w_hazard && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_instr <= 32'h0;
      r_pc    <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_instr <= instr_i;
        r_pc    <= pc_i;
      end
    end
  end

  // Set is applied after clear so an issuing writer wins over a same-cycle writeback.
  always_comb begin
    w_pending_nxt = r_pending;
    if (wb_valid_i) w_pending_nxt[wb_rd_i] = 1'b0;
    if (w_issue_fire && r_regwen) w_pending_nxt[r_addr_d] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending   <= 32'h0;
      r_stall_cnt <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_stall && (r_stall_cnt != {SCNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(SCNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_opcode  <= 7'h0;
      r_funct3  <= 3'h0;
      r_funct7  <= 7'h0;
      r_imm     <= 32'h0;
      r_pc_out  <= 32'h0;
      r_illegal <= 1'b0;
      r_addr_d  <= 5'h0;
      r_regwen  <= 1'b0;
    end else if (w_decode_done) begin
      r_opcode  <= w_opcode;
      r_funct3  <= w_funct3;
      r_funct7  <= w_funct7;
      r_imm     <= w_imm;
      r_pc_out  <= r_pc;
      r_illegal <= w_illegal;
      r_addr_d  <= w_writes ? w_rd : 5'h0;
      r_regwen  <= w_writes && (w_rd != 5'h0);
    end
  end

  // Read addresses come straight from the held word so the regfile sees them from the
  // first CHECK cycle, giving its registered read time to land before issue.
  assign AddrA_o       = ((r_state != ST_IDLE) && w_use_rs1) ? w_rs1 : 5'h0;
  assign AddrB_o       = ((r_state != ST_IDLE) && w_use_rs2) ? w_rs2 : 5'h0;
  assign issue_valid_o = (r_state == ST_ISSUE);
  assign AddrD_o       = issue_valid_o ? r_addr_d : 5'h0;
  assign RegWEn_o      = issue_valid_o && r_regwen;
  assign instr_ready_o = w_instr_ready;
  assign opcode_o      = r_opcode;
  assign funct3_o      = r_funct3;
  assign funct7_o      = r_funct7;
  assign imm_o         = r_imm;
  assign pc_o          = r_pc_out;
  assign illegal_o     = r_illegal;
  assign stall_cnt_o   = r_stall_cnt;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_riscv_decode_issue.sv
// Bench for riscv_decode_issue: directed timing scenarios plus a randomized run, with a
// scoreboard that checks every issued instruction against a reference decode.
module tb_riscv_decode_issue;

  localparam int SW = 4;
  localparam int EW = 98;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  d;
    logic        regwen;
    logic        illegal;
  } exp_t;

  logic          clk;
  logic          rst_i;
  logic          instr_valid_i;
  logic [31:0]   instr_i;
  logic [31:0]   pc_i;
  logic          instr_ready_o;
  logic          flush_i;
  logic          wb_valid_i;
  logic [4:0]    wb_rd_i;
  logic [4:0]    AddrA_o;
  logic [4:0]    AddrB_o;
  logic [4:0]    AddrD_o;
  logic          RegWEn_o;
  logic          issue_valid_o;
  logic          issue_ready_i;
  logic [6:0]    opcode_o;
  logic [2:0]    funct3_o;
  logic [6:0]    funct7_o;
  logic [31:0]   imm_o;
  logic [31:0]   pc_o;
  logic          illegal_o;
  logic [SW-1:0] stall_cnt_o;
  logic [1:0]    dbg_state_o;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   p_model;
  logic [31:0]   p_prev;
  logic [31:0]   p_next;
  logic          was_busy;
  logic          fetch_done;
  exp_t          e_mon;

  riscv_decode_issue #(.SCNT_W(SW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .instr_ready_o (instr_ready_o),
    .flush_i       (flush_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .AddrA_o       (AddrA_o),
    .AddrB_o       (AddrB_o),
    .AddrD_o       (AddrD_o),
    .RegWEn_o      (RegWEn_o),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .opcode_o      (opcode_o),
    .funct3_o      (funct3_o),
    .funct7_o      (funct7_o),
    .imm_o         (imm_o),
    .pc_o          (pc_o),
    .illegal_o     (illegal_o),
    .stall_cnt_o   (stall_cnt_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
  endfunction

  function automatic logic [EW-1:0] model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    bit   u1 = 0, u2 = 0, wr = 0;
    int   imm_v = 0;
    case (ins[6:0])
      7'h33: begin u1 = 1; u2 = 1; wr = 1; end
      7'h13, 7'h03, 7'h67: begin u1 = 1; wr = 1; imm_v = sext(int'(ins[31:20]), 12); end
      7'h23: begin u1 = 1; u2 = 1; imm_v = sext(int'({ins[31:25], ins[11:7]}), 12); end
      7'h63: begin
        u1 = 1; u2 = 1;
        imm_v = sext(int'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12) * 2;
      end
      7'h37, 7'h17: begin wr = 1; imm_v = int'(ins[31:12]) * 4096; end
      7'h6F: begin
        wr = 1;
        imm_v = sext(int'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20) * 2;
      end
      default: ;
    endcase
    e.pc      = pc;
    e.imm     = imm_v;
    e.opcode  = ins[6:0];
    e.f3      = ins[14:12];
    e.f7      = ins[31:25];
    e.a       = u1 ? ins[19:15] : 5'd0;
    e.b       = u2 ? ins[24:20] : 5'd0;
    e.d       = wr ? ins[11:7] : 5'd0;
    e.regwen  = wr && (ins[11:7] != 5'd0);
    e.illegal = !is_legal(ins[6:0]);
    return e;
  endfunction

  function automatic logic [EW-1:0] dut_vec();
    return {pc_o, imm_o, opcode_o, funct3_o, funct7_o, AddrA_o, AddrB_o, AddrD_o,
            RegWEn_o, illegal_o};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    p_model  = 32'h0;
    p_prev   = 32'h0;
    was_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        exp_q.delete();
        p_model  = 32'h0;
        p_prev   = 32'h0;
        was_busy = 1'b0;
      end else begin
        p_next = p_model;
        if (wb_valid_i) p_next[wb_rd_i] = 1'b0;
        if (flush_i) begin
          exp_q.delete();
          was_busy = 1'b0;
        end else begin
          if (issue_valid_o && !was_busy) begin
            if (exp_q.size() == 0) begin
              check("issue_unexpected", 1, 0);
            end else begin
              e_mon = exp_t'(exp_q[0]);
              check("issued_over_hazard",
                    ((e_mon.a != 0) && p_prev[e_mon.a]) || ((e_mon.b != 0) && p_prev[e_mon.b]),
                    0);
            end
          end
          if (issue_valid_o && issue_ready_i) begin
            if (exp_q.size() == 0) begin
              check("handshake_unexpected", 1, 0);
            end else begin
              e_mon = exp_t'(exp_q.pop_front());
              check("issue_data", dut_vec(), e_mon);
              if (e_mon.regwen) p_next[e_mon.d] = 1'b1;
            end
          end
          if (instr_valid_i && instr_ready_o) exp_q.push_back(model(instr_i, pc_i));
          was_busy = issue_valid_o && !issue_ready_i;
        end
        p_next[0] = 1'b0;
        p_prev  = p_model;
        p_model = p_next;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    bit done = 0;
    int k = 0;
    instr_valid_i = 1'b1;
    instr_i       = ins;
    pc_i          = pc;
    while (!done && k < 200) begin
      @(negedge clk);
      if (instr_ready_o) done = 1;
      tick();
      k++;
    end
    instr_valid_i = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_issue(output int n);
    bit seen = 0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (issue_valid_o) seen = 1;
    end
    if (!seen) check("issue_timeout", 0, 1);
  endtask

  task automatic drive_wb_random();
    int cand[$];
    for (int r = 1; r < 32; r++) if (p_model[r]) cand.push_back(r);
    if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
      wb_valid_i = 1'b1;
      wb_rd_i    = 5'(cand[$urandom_range(0, cand.size() - 1)]);
    end else if ($urandom_range(0, 5) == 0) begin
      wb_valid_i = 1'b1;
      wb_rd_i    = 5'($urandom_range(0, 31));
    end else begin
      wb_valid_i = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  op;
    int          c;
    w = $urandom();
    c = $urandom_range(0, 9);
    case (c)
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h03;
      3: op = 7'h67;
      4: op = 7'h23;
      5: op = 7'h63;
      6: op = 7'h37;
      7: op = 7'h17;
      8: op = 7'h6F;
      default: begin
        op = 7'($urandom_range(0, 127));
        while (is_legal(op)) op = op + 7'd1;
      end
    endcase
    w[6:0]   = op;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // ---------------- stimulus ----------------
  logic [EW-1:0] snap;
  int            n;

  initial begin
    rst_i         = 1'b1;
    instr_valid_i = 1'b0;
    instr_i       = 32'h0;
    pc_i          = 32'h0;
    flush_i       = 1'b0;
    wb_valid_i    = 1'b0;
    wb_rd_i       = 5'h0;
    issue_ready_i = 1'b0;
    fetch_done    = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_issue_valid", issue_valid_o, 0);
    check("rst_instr_ready", instr_ready_o, 1);
    check("rst_stall_cnt", stall_cnt_o, 0);
    check("rst_outputs", dut_vec(), 0);
    check("rst_state", dbg_state_o, 0);
    tick();
    rst_i = 1'b0;

    // addi x1,x0,5 at 0x100: issued two cycles after acceptance
    issue_ready_i = 1'b1;
    send(32'h00500093, 32'h100);
    wait_issue(n);
    check("addi_latency", n, 2);
    check("addi_fields", {AddrD_o, imm_o, RegWEn_o, AddrA_o, pc_o},
          {5'd1, 32'd5, 1'b1, 5'd0, 32'h100});
    tick();

    // add x2,x1,x1 waits for x1 writeback
    send(32'h00108133, 32'h104);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("raw_hold", {issue_valid_o, AddrA_o, AddrB_o, stall_cnt_o},
            {1'b0, 5'd1, 5'd1, SW'(i)});
      tick();
    end
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd1;
    @(negedge clk);
    check("raw_hold_wb", {issue_valid_o, stall_cnt_o}, {1'b0, SW'(3)});
    tick();
    wb_valid_i = 1'b0;
    wait_issue(n);
    check("raw_release_latency", n, 2);
    check("raw_stall_cnt", stall_cnt_o, 4);
    tick();

    // immediate decode
    send(32'hFE000EE3, 32'h108);
    wait_issue(n);
    check("beq_imm_wen", {imm_o, RegWEn_o, AddrD_o}, {32'hFFFFFFFC, 1'b0, 5'd0});
    tick();
    send(32'h123452B7, 32'h10C);
    wait_issue(n);
    check("lui_imm_rd", {imm_o, AddrD_o, RegWEn_o}, {32'h12345000, 5'd5, 1'b1});
    tick();

    // backpressure with a waiting instruction
    issue_ready_i = 1'b0;
    send(32'h00700313, 32'h110);
    wait_issue(n);
    snap = dut_vec();
    tick();
    instr_valid_i = 1'b1;
    instr_i       = 32'h00900393;
    pc_i          = 32'h114;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stable", {dut_vec(), issue_valid_o, instr_ready_o}, {snap, 1'b1, 1'b0});
      tick();
    end
    issue_ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_ready", instr_ready_o, 1);
    tick();
    instr_valid_i = 1'b0;
    wait_issue(n);
    check("bp_next_latency", n, 2);
    tick();

    // same-cycle set and clear of x3: set wins
    issue_ready_i = 1'b0;
    send(32'h00100193, 32'h118);
    wait_issue(n);
    tick();
    issue_ready_i = 1'b1;
    wb_valid_i    = 1'b1;
    wb_rd_i       = 5'd3;
    @(negedge clk);
    tick();
    wb_valid_i = 1'b0;
    send(32'h00018233, 32'h11C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("x3_still_pending", issue_valid_o, 0);
      tick();
    end
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd3;
    @(negedge clk);
    tick();
    wb_valid_i = 1'b0;
    wait_issue(n);
    check("x3_release_latency", n, 2);
    tick();

    // writer to x0 never marks the scoreboard
    send(32'h00000013, 32'h120);
    wait_issue(n);
    check("x0_writer_wen", {RegWEn_o, AddrD_o}, 0);
    tick();
    send(32'h00000433, 32'h124);
    wait_issue(n);
    check("x0_no_hazard", n, 2);
    tick();

    // flush during ISSUE beats the handshake and leaves the scoreboard alone
    issue_ready_i = 1'b0;
    send(32'h00300493, 32'h128);
    wait_issue(n);
    tick();
    flush_i       = 1'b1;
    issue_ready_i = 1'b1;
    @(negedge clk);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle", {issue_valid_o, instr_ready_o, dbg_state_o}, {1'b0, 1'b1, 2'd0});
    tick();
    send(32'h00048533, 32'h12C);
    wait_issue(n);
    check("flush_no_set", n, 2);
    tick();
    send(32'h000285B3, 32'h130);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_kept_pending", issue_valid_o, 0);
      tick();
    end
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd5;
    @(negedge clk);
    tick();
    wb_valid_i = 1'b0;
    wait_issue(n);
    check("x5_release_latency", n, 2);
    tick();

    // illegal opcode is issued and does not touch the scoreboard
    send(32'h0000007F, 32'h134);
    wait_issue(n);
    check("illegal_fields", {n[3:0], illegal_o, imm_o, RegWEn_o}, {4'd2, 1'b1, 32'h0, 1'b0});
    tick();
    send(32'h0000077F, 32'h138);
    wait_issue(n);
    tick();
    send(32'h00070633, 32'h13C);
    wait_issue(n);
    check("illegal_no_set", n, 2);
    tick();

    // long stall saturates the counter, then async reset mid-stall
    send(32'h00100793, 32'h140);
    wait_issue(n);
    tick();
    send(32'h00F78833, 32'h144);
    repeat (20) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    check("stall_saturate", {issue_valid_o, stall_cnt_o}, {1'b0, {SW{1'b1}}});
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_outputs", {dut_vec(), issue_valid_o, instr_ready_o, stall_cnt_o},
          {{EW{1'b0}}, 1'b0, 1'b1, {SW{1'b0}}});
    tick();
    @(negedge clk);
    tick();
    rst_i = 1'b0;
    send(32'h00F78833, 32'h148);
    wait_issue(n);
    check("rst_cleared_scoreboard", n, 2);
    tick();

    // randomized traffic
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          send(rand_instr(), 32'h1000 + 32'(i * 4));
        end
        fetch_done = 1'b1;
      end
      begin
        while (!fetch_done) begin
          issue_ready_i = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
      begin
        while (!fetch_done) begin
          drive_wb_random();
          tick();
        end
      end
    join
    issue_ready_i = 1'b1;
    begin
      int k = 0;
      while ((exp_q.size() != 0 || issue_valid_o) && k < 500) begin
        drive_wb_random();
        tick();
        k++;
      end
      wb_valid_i = 1'b0;
      check("random_drain", exp_q.size(), 0);
    end
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
